// File: rtl/starter_menu_fsm.sv
// Starter-selection menu FSM: browse species with A/D, confirm with Enter, back out with Esc, then evolve.
// Define STARTER_WRAP_EN so the cursor wraps at either end; without it the cursor saturates.
module starter_menu_fsm (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       menu_start,
  input  logic       evolve,
  output logic [1:0] cursor,
  output logic       menu_active,
  output logic       confirm_prompt,
  output logic       cursor_blink,
  output logic [3:0] chosenPokemon,
  output logic       chosen_valid
);

  typedef enum logic [1:0] {S_IDLE, S_BROWSE, S_CONFIRM, S_LOCKED} state_e;

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_ACCEPT = 8'h28;
  localparam logic [7:0] KEY_BACK   = 8'h29;
  localparam logic [1:0] MAX_IDX    = 2'd2;
  localparam logic [3:0] NO_CHOICE  = 4'b1111;

  state_e     state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic [1:0] species_q, species_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       cursor_blink_q, cursor_blink_d;
  logic [7:0] prev_key_q;
  logic       menu_active_q, menu_active_d;
  logic       confirm_prompt_q, confirm_prompt_d;
  logic       chosen_valid_q, chosen_valid_d;
  logic [3:0] chosen_q, chosen_d;

  logic press, key_left, key_right, key_accept, key_back;

  function automatic logic [1:0] step_left(input logic [1:0] c);
`ifdef STARTER_WRAP_EN
    return (c == 2'd0) ? MAX_IDX : c - 2'd1;
`else
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
`endif
  endfunction

  function automatic logic [1:0] step_right(input logic [1:0] c);
`ifdef STARTER_WRAP_EN
    return (c >= MAX_IDX) ? 2'd0 : c + 2'd1;
`else
    return (c >= MAX_IDX) ? MAX_IDX : c + 2'd1;
`endif
  endfunction

  // A held key yields one event: only a change to a non-zero code counts.
  assign press      = (keycode != 8'h00) && (keycode != prev_key_q);
  assign key_left   = press && (keycode == KEY_LEFT);
  assign key_right  = press && (keycode == KEY_RIGHT);
  assign key_accept = press && (keycode == KEY_ACCEPT);
  assign key_back   = press && (keycode == KEY_BACK);

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d   = state_q;
    cursor_d  = cursor_q;
    species_d = species_q;
    stage_d   = stage_q;
    unique case (state_q)
      S_IDLE: begin
        if (menu_start) begin
          state_d  = S_BROWSE;
          cursor_d = 2'd0;
        end
      end
      S_BROWSE: begin
        if (key_accept)     state_d  = S_CONFIRM;
        else if (key_back)  state_d  = S_IDLE;
        else if (key_left)  cursor_d = step_left(cursor_q);
        else if (key_right) cursor_d = step_right(cursor_q);
      end
      S_CONFIRM: begin
        if (key_accept) begin
          state_d   = S_LOCKED;
          species_d = cursor_q;
          stage_d   = 2'd0;
        end else if (key_back) begin
          state_d = S_BROWSE;
        end
      end
      S_LOCKED: begin
        if (evolve && (stage_q != MAX_IDX)) stage_d = stage_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    menu_active_d    = (state_d == S_BROWSE) || (state_d == S_CONFIRM);
    confirm_prompt_d = (state_d == S_CONFIRM);
    chosen_valid_d   = (state_d == S_LOCKED);
    chosen_d         = chosen_valid_d
                     ? ({2'b00, stage_d} << 1) + {2'b00, stage_d} + {2'b00, species_d}
                     : NO_CHOICE;

    // Blink runs on frames seen while the menu is shown; it is zeroed once the menu closes.
    blink_cnt_d    = blink_cnt_q;
    cursor_blink_d = cursor_blink_q;
    if (!menu_active_d) begin
      blink_cnt_d    = 4'd0;
      cursor_blink_d = 1'b0;
    end else if (menu_active_q && frame_tick) begin
      blink_cnt_d = blink_cnt_q + 4'd1;
      if (blink_cnt_q == 4'hF) cursor_blink_d = ~cursor_blink_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= S_IDLE;
      cursor_q         <= 2'd0;
      species_q        <= 2'd0;
      stage_q          <= 2'd0;
      blink_cnt_q      <= 4'd0;
      cursor_blink_q   <= 1'b0;
      prev_key_q       <= 8'h00;
      menu_active_q    <= 1'b0;
      confirm_prompt_q <= 1'b0;
      chosen_valid_q   <= 1'b0;
      chosen_q         <= NO_CHOICE;
    end else begin
      state_q          <= state_d;
      cursor_q         <= cursor_d;
      species_q        <= species_d;
      stage_q          <= stage_d;
      blink_cnt_q      <= blink_cnt_d;
      cursor_blink_q   <= cursor_blink_d;
      prev_key_q       <= keycode;
      menu_active_q    <= menu_active_d;
      confirm_prompt_q <= confirm_prompt_d;
      chosen_valid_q   <= chosen_valid_d;
      chosen_q         <= chosen_d;
    end
  end

  assign cursor         = cursor_q;
  assign menu_active    = menu_active_q;
  assign confirm_prompt = confirm_prompt_q;
  assign cursor_blink   = cursor_blink_q;
  assign chosenPokemon  = chosen_q;
  assign chosen_valid   = chosen_valid_q;

endmodule

// File: tb/tb_starter_menu_fsm.sv
// Directed bench for starter_menu_fsm: a vector table plus hand-written multi-cycle sequences.
module tb_starter_menu_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic       menu_start = 1'b0;
  logic       evolve = 1'b0;
  logic [1:0] cursor;
  logic       menu_active, confirm_prompt, cursor_blink, chosen_valid;
  logic [3:0] chosenPokemon;

  int n_vec = 0;
  int n_err = 0;

`ifdef STARTER_WRAP_EN
  localparam logic [1:0] RIGHT_AT2 = 2'd0;
  localparam logic [1:0] LEFT_AT0  = 2'd2;
`else
  localparam logic [1:0] RIGHT_AT2 = 2'd2;
  localparam logic [1:0] LEFT_AT0  = 2'd0;
`endif

  starter_menu_fsm dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .menu_start    (menu_start),
    .evolve        (evolve),
    .cursor        (cursor),
    .menu_active   (menu_active),
    .confirm_prompt(confirm_prompt),
    .cursor_blink  (cursor_blink),
    .chosenPokemon (chosenPokemon),
    .chosen_valid  (chosen_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst, ms, ev, ft;
    logic [7:0] key;
    logic [1:0] cur;
    logic       act, conf, val, blk;
    logic [3:0] ch;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic ms, input logic ev, input logic ft, input logic [7:0] key);
    Reset = r; menu_start = ms; evolve = ev; frame_tick = ft; keycode = key;
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] key);
    step(0, 0, 0, 0, key);
    step(0, 0, 0, 0, 8'h00);
  endtask

  function automatic logic [15:0] pack_out();
    return {6'd0, cursor, menu_active, confirm_prompt, chosen_valid, cursor_blink, chosenPokemon};
  endfunction

  function automatic logic [15:0] pack_exp(input vec_t v);
    return {6'd0, v.cur, v.act, v.conf, v.val, v.blk, v.ch};
  endfunction

  initial begin
    //          rst ms ev ft key     cur  act conf val blk ch
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 2'd0, 0, 0, 0, 0, 4'hF};
    vecs[1]  = '{0, 0, 0, 0, 8'h07, 2'd0, 0, 0, 0, 0, 4'hF};
    vecs[2]  = '{0, 0, 0, 0, 8'h00, 2'd0, 0, 0, 0, 0, 4'hF};
    vecs[3]  = '{0, 1, 0, 0, 8'h07, 2'd0, 1, 0, 0, 0, 4'hF};
    vecs[4]  = '{0, 0, 0, 0, 8'h07, 2'd0, 1, 0, 0, 0, 4'hF};
    vecs[5]  = '{0, 0, 0, 0, 8'h00, 2'd0, 1, 0, 0, 0, 4'hF};
    vecs[6]  = '{0, 0, 0, 0, 8'h07, 2'd1, 1, 0, 0, 0, 4'hF};
    vecs[7]  = '{0, 0, 0, 0, 8'h00, 2'd1, 1, 0, 0, 0, 4'hF};
    vecs[8]  = '{0, 0, 0, 0, 8'h07, 2'd2, 1, 0, 0, 0, 4'hF};
    vecs[9]  = '{0, 0, 0, 0, 8'h28, 2'd2, 1, 1, 0, 0, 4'hF};
    vecs[10] = '{0, 0, 0, 0, 8'h04, 2'd2, 1, 1, 0, 0, 4'hF};
    vecs[11] = '{0, 0, 0, 0, 8'h29, 2'd2, 1, 0, 0, 0, 4'hF};
    vecs[12] = '{0, 0, 0, 0, 8'h28, 2'd2, 1, 1, 0, 0, 4'hF};
    vecs[13] = '{0, 0, 0, 0, 8'h00, 2'd2, 1, 1, 0, 0, 4'hF};
    vecs[14] = '{0, 0, 0, 0, 8'h28, 2'd2, 0, 0, 1, 0, 4'h2};
    vecs[15] = '{0, 0, 1, 0, 8'h00, 2'd2, 0, 0, 1, 0, 4'h5};
    vecs[16] = '{0, 1, 1, 0, 8'h00, 2'd2, 0, 0, 1, 0, 4'h8};
    vecs[17] = '{0, 0, 1, 0, 8'h00, 2'd2, 0, 0, 1, 0, 4'h8};
    vecs[18] = '{0, 0, 0, 0, 8'h29, 2'd2, 0, 0, 1, 0, 4'h8};
    vecs[19] = '{1, 0, 1, 0, 8'h00, 2'd0, 0, 0, 0, 0, 4'hF};
    vecs[20] = '{0, 0, 0, 0, 8'h00, 2'd0, 0, 0, 0, 0, 4'hF};

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].ms, vecs[i].ev, vecs[i].ft, vecs[i].key);
      check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end

    // Lock species 1, then evolve three times with saturation at stage 2.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    press(8'h07);
    press(8'h28);
    check("confirm_prompt_s1", {15'd0, confirm_prompt}, 16'd1);
    press(8'h28);
    check("locked_s1", {11'd0, chosen_valid, chosenPokemon}, {11'd0, 1'b1, 4'b0001});
    step(0, 0, 1, 0, 8'h00);
    check("evolve1", {12'd0, chosenPokemon}, 16'h4);
    step(0, 0, 1, 0, 8'h00);
    check("evolve2", {12'd0, chosenPokemon}, 16'h7);
    step(0, 0, 1, 0, 8'h00);
    check("evolve3_sat", {12'd0, chosenPokemon}, 16'h7);

    // Holding D for ten cycles moves the cursor only once.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'h07);
    check("hold_d", {14'd0, cursor}, 16'd1);
    step(0, 0, 0, 0, 8'h00);
    check("hold_d_release", {14'd0, cursor}, 16'd1);

    // Right edge: D at cursor 2.
    press(8'h07);
    check("cursor_at2", {14'd0, cursor}, 16'd2);
    press(8'h07);
    check("right_at2", {14'd0, cursor}, {14'd0, RIGHT_AT2});

    // Left edge: A at cursor 0.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    press(8'h04);
    check("left_at0", {14'd0, cursor}, {14'd0, LEFT_AT0});

    // Blink toggles on the 16th frame in BROWSE; Esc back to IDLE clears it.
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 8'h00);
    check("blink_15", {15'd0, cursor_blink}, 16'd0);
    step(0, 0, 0, 1, 8'h00);
    check("blink_16", {15'd0, cursor_blink}, 16'd1);
    step(0, 0, 0, 0, 8'h29);
    check("esc_idle", {10'd0, menu_active, cursor_blink, chosenPokemon}, {10'd0, 1'b0, 1'b0, 4'hF});

    // A frame tick in IDLE must not advance the blink state.
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
    check("blink_idle", {15'd0, cursor_blink}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
